// File: rtl/regfile_stream_reader.sv
// regfile_stream_reader
//
// Sweeps a run of register-file words and presents them as a valid/ready stream.
// A sweep starts from IDLE on `start`. It reads min(count, N) words beginning at
// base_addr. The read address wraps modulo N.
//
// Stream handshake: a word transfers on a rising clk edge when m_valid=1 and
// m_ready=1. Once m_valid is raised, m_data/m_last (and rd_addr) stay stable
// until that transfer occurs. m_last marks the final word of the sweep.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   start      : sweep request, only looked at in IDLE
//   base_addr  : first word address, sampled with start
//   count      : number of words to read (0..2N-1), sampled with start
//   rd_addr    : registered register-file read address
//   rd_data    : combinational register-file read data for rd_addr
//   m_data     : registered stream data
//   m_valid    : stream data valid
//   m_ready    : downstream accept
//   m_last     : final word of the sweep
//   busy       : high exactly while a sweep is in READ
//   done       : one-cycle pulse after the sweep completes (or for count=0)
//   dbg_state  : current FSM state (0=IDLE, 1=READ, 2=DONE)
module regfile_stream_reader #(
  parameter int M = 4,
  parameter int N = 16,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [M-1:0] base_addr,
  input  logic [M:0]   count,
  output logic [M-1:0] rd_addr,
  input  logic [W-1:0] rd_data,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         m_last,
  output logic         busy,
  output logic         done,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [M:0] N_WORDS = (M+1)'(N);
  localparam logic [M:0] ONE     = (M+1)'(1);

  state_t       state;
  state_t       state_nxt;
  logic [M:0]   remaining;
  logic [M:0]   count_clamped;
  logic         hs;
  logic         capture;
  logic         launch;

  // A count larger than the register file still visits each word only once.
  assign count_clamped = (count > N_WORDS) ? N_WORDS : count;

  assign hs     = m_valid & m_ready;
  assign launch = (state == S_IDLE) && start && (count != '0);

  // Refill the output register whenever it is empty or being drained this edge.
  // This gives one word per cycle under m_ready=1 without a skid buffer.
  assign capture = (state == S_READ) && (remaining != '0) && (!m_valid || hs);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (count == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        // With nothing left to fetch, the word on the bus is the m_last one.
        if ((remaining == '0) && hs) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = (state == S_READ);
    done      = (state == S_DONE);
    dbg_state = state;
  end

  // Datapath: read address, word counter and stream output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr   <= '0;
      remaining <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
    end else begin
      if (launch) begin
        rd_addr   <= base_addr;
        remaining <= count_clamped;
      end else if (capture) begin
        m_data    <= rd_data;
        m_valid   <= 1'b1;
        m_last    <= (remaining == ONE);
        rd_addr   <= rd_addr + 1'b1;
        remaining <= remaining - ONE;
      end else if ((state == S_READ) && (remaining == '0) && hs) begin
        m_valid   <= 1'b0;
        m_last    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_stream_reader.sv
// Testbench for regfile_stream_reader (M=4, N=16, W=8).
// The register file is modelled by an array in the bench. It drives rd_data
// combinationally from rd_addr.
module tb_regfile_stream_reader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] base_addr;
  logic [4:0] count;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;
  logic       busy;
  logic       done;
  logic [1:0] dbg_state;

  logic [7:0] regfile [16];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] base;
    logic [4:0] cnt;
    int         exp_n;      // hand-computed number of words expected
    int         ready_mode; // 0: m_ready held 1, 1: pattern 1,0,0,1 repeating
    int         inject_at;  // cycle at which a start is pulsed while busy (-1: none)
  } vec_t;

  vec_t vecs [7];

  regfile_stream_reader #(.M(4), .N(16), .W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  assign rd_data = regfile[rd_addr];

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Runs one sweep. The task is entered and left at posedge+1.
  // Cycle 0 of the loop is the cycle after start was sampled.
  task automatic run_vec(input vec_t v);
    logic [7:0] exp_q[$];
    int         got;
    int         last_hs;
    int         done_cyc;
    bit         stall;
    logic [7:0] pd;
    logic       pl;
    logic [3:0] pa;
    got = 0; last_hs = -1; done_cyc = -1; stall = 0;
    pd = '0; pl = 1'b0; pa = '0;
    for (int i = 0; i < v.exp_n; i++) exp_q.push_back(regfile[4'(v.base + i)]);

    start = 1'b1; base_addr = v.base; count = v.cnt; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    for (int cyc = 0; cyc < 200; cyc++) begin
      if (v.inject_at == cyc) begin
        start = 1'b1; base_addr = 4'd5; count = 5'd2;
      end
      m_ready = (v.ready_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      @(negedge clk);
      if (cyc == 0 && v.exp_n > 0) begin
        chk("first_cycle_valid", m_valid, 0);
        chk("first_cycle_busy", busy, 1);
        chk("first_cycle_rd_addr", rd_addr, v.base);
      end
      if (cyc == 1 && v.exp_n > 0) chk("latency_c2_valid", m_valid, 1);
      if (v.ready_mode == 0 && cyc < v.exp_n) chk("rd_addr_seq", rd_addr, 4'(v.base + cyc));
      if (stall) begin
        chk("stall_data_stable", m_data, pd);
        chk("stall_last_stable", m_last, pl);
        chk("stall_rd_addr_stable", rd_addr, pa);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_word_valid", m_valid, 0);
        end else begin
          chk("word_data", m_data, exp_q[0]);
          chk("word_last", m_last, (exp_q.size() == 1));
          void'(exp_q.pop_front());
          got++;
          last_hs = cyc;
        end
      end
      stall = m_valid && !m_ready;
      pd = m_data; pl = m_last; pa = rd_addr;
      if (done) begin
        done_cyc = cyc;
        chk("done_busy_low", busy, 0);
        chk("done_valid_low", m_valid, 0);
        break;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end

    if (done_cyc < 0) chk("done_timeout", done, 1);
    chk("word_count", got, v.exp_n);
    chk("done_timing", done_cyc, (v.exp_n == 0) ? 0 : last_hs + 1);

    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_valid", m_valid, 0);
    if (v.exp_n > 0) chk("idle_rd_addr_hold", rd_addr, 4'(v.base + v.exp_n));
    @(posedge clk); #1;
  endtask

  initial begin
    int nhs;
    vecs[0] = '{base: 4'd0,  cnt: 5'd16, exp_n: 16, ready_mode: 0, inject_at: -1};
    vecs[1] = '{base: 4'd14, cnt: 5'd4,  exp_n: 4,  ready_mode: 0, inject_at: -1};
    vecs[2] = '{base: 4'd3,  cnt: 5'd9,  exp_n: 9,  ready_mode: 1, inject_at: -1};
    vecs[3] = '{base: 4'd0,  cnt: 5'd0,  exp_n: 0,  ready_mode: 0, inject_at: -1};
    vecs[4] = '{base: 4'd7,  cnt: 5'd20, exp_n: 16, ready_mode: 0, inject_at: -1};
    vecs[5] = '{base: 4'd0,  cnt: 5'd16, exp_n: 16, ready_mode: 0, inject_at: 4};
    vecs[6] = '{base: 4'd15, cnt: 5'd1,  exp_n: 1,  ready_mode: 1, inject_at: -1};

    for (int i = 0; i < 16; i++) regfile[i] = 8'(i + 8'h10);
    rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0; m_ready = 1'b0;

    #12;
    chk("reset_rd_addr", rd_addr, 0);
    chk("reset_m_valid", m_valid, 0);
    chk("reset_m_data", m_data, 0);
    chk("reset_m_last", m_last, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_state", dbg_state, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Spot values for the full sweep and the wrap, computed by hand.
    chk("hand_rf0", regfile[0], 8'h10);
    chk("hand_rf15", regfile[15], 8'h1F);

    for (int i = 0; i < 7; i++) begin
      if (i == 2) begin
        for (int j = 0; j < 16; j++) regfile[j] = 8'(j * 7 + 3);
      end
      run_vec(vecs[i]);
    end

    // Reset asserted mid-sweep, at word 5 of 16.
    for (int j = 0; j < 16; j++) regfile[j] = 8'(8'hA0 + j);
    start = 1'b1; base_addr = 4'd0; count = 5'd16; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nhs = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk);
      if (m_valid && m_ready) nhs++;
      if (nhs == 5) break;
      @(posedge clk); #1;
    end
    chk("rst_sweep_reached_word5", nhs, 5);
    chk("pre_rst_valid", m_valid, 1);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_data", m_data, 8'hA4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", m_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_last", m_last, 0);
    chk("async_rst_data", m_data, 0);
    chk("async_rst_rd_addr", rd_addr, 0);
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      chk("rst_no_done", done, 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_no_done", done, 0);
    chk("post_rst_idle", dbg_state, 0);
    @(posedge clk); #1;

    // The first start after reset behaves as a normal launch.
    run_vec('{base: 4'd2, cnt: 5'd3, exp_n: 3, ready_mode: 0, inject_at: -1});
    run_vec('{base: 4'd9, cnt: 5'd0, exp_n: 0, ready_mode: 1, inject_at: -1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Bounded run time in case a DUT fault stalls the bench.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/regfile_stream_reader.md
REGFILE_STREAM_READER -- requirements
Module: regfile_stream_reader

Interface
REQ-001 SHALL have parameter M, default 4, meaning the number of address bits.
REQ-002 SHALL have parameter N, default 16, meaning the number of words (N = 2^M).
REQ-003 SHALL have parameter W, default 8, meaning the word width in bits.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port start, input, 1 bit: sweep request, sampled only in IDLE.
REQ-007 SHALL have port base_addr, input, M bits: first word address, sampled with start.
REQ-008 SHALL have port count, input, M+1 bits: number of words to read, sampled with start.
REQ-009 SHALL have port rd_addr, output, M bits: registered read address driven to the register-file read port.
REQ-010 SHALL have port rd_data, input, W bits: combinational read data returned for rd_addr.
REQ-011 SHALL have port m_data, output, W bits: registered stream data.
REQ-012 SHALL have port m_valid, output, 1 bit: stream data valid.
REQ-013 SHALL have port m_ready, input, 1 bit: downstream accept.
REQ-014 SHALL have port m_last, output, 1 bit: marks the final word of a sweep.
REQ-015 SHALL have port busy, output, 1 bit: a sweep is in progress.
REQ-016 SHALL have port done, output, 1 bit: one-cycle sweep-complete pulse.

Function
REQ-017 SHALL implement the states IDLE, READ and DONE.
REQ-018 In IDLE with start=1 and count>0, SHALL load rd_addr<=base_addr and remaining<=min(count,N), then enter READ.
REQ-019 In IDLE with start=1 and count=0, SHALL enter DONE without asserting m_valid.
REQ-020 SHALL ignore start in every state except IDLE.
REQ-021 A handshake SHALL occur on a clock edge when m_valid=1 and m_ready=1.
REQ-022 In READ, SHALL capture a word when remaining>0 and (m_valid=0 or a handshake occurs): m_data<=rd_data, m_valid<=1, m_last<=(remaining==1), rd_addr<=rd_addr+1 modulo N, remaining<=remaining-1.
REQ-023 Latency SHALL be fixed: with start high in cycle c, the first m_valid appears in cycle c+2.
REQ-024 Throughput SHALL be one word per cycle while m_ready is held at 1.
REQ-025 While m_valid=1 and m_ready=0, m_data, m_last and rd_addr SHALL hold stable.
REQ-026 When remaining=0 and the handshake completes with m_last=1, SHALL clear m_valid and m_last and enter DONE.
REQ-027 When remaining=0, m_valid and m_last SHALL clear on a handshake.
REQ-028 DONE SHALL last exactly one cycle, with done=1 and busy=0, and SHALL then return to IDLE.
REQ-029 busy SHALL equal 1 exactly when the state is READ.
REQ-030 Address wrap: rd_addr SHALL step from N-1 to 0 and continue.
REQ-031 When count>N, the block SHALL stream exactly N words, each address once.
REQ-032 Each word's value SHALL be rd_data at its capture edge, so register-file writes completed before that edge are visible.
REQ-033 In IDLE, rd_addr SHALL hold its last value and m_valid SHALL be 0.

Reset
REQ-034 On rst_n=0, SHALL immediately, without waiting for clk, force state=IDLE and zero rd_addr, remaining, m_data, m_valid, m_last, busy and done.
REQ-035 Reset asserted mid-sweep SHALL abandon the sweep with no done pulse.
REQ-036 After rst_n deasserts, the first start SHALL behave per REQ-018/019.

Verification
REQ-037 Bench SHALL check full sweep: regfile[i]=i+8'h10, base=0, count=16, m_ready=1 -> 16 consecutive words 10..1F, m_last only on 1F, done one cycle after.
REQ-038 Bench SHALL check wrap: base=14, count=4 -> rd_addr sequence 14,15,0,1; data words regfile[14],[15],[0],[1].
REQ-039 Bench SHALL check backpressure: m_ready toggled 1,0,0,1,... -> m_data stable while stalled, no word lost or duplicated.
REQ-040 Bench SHALL check count=0 and count=20: 0 -> done in cycle c+1, no m_valid; 20 -> exactly 16 words.
REQ-041 Bench SHALL check start while busy is ignored, and rst_n pulled low at word 5 of 16 -> m_valid/busy drop asynchronously, no done pulse.
